mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one unified memory between a CPU and a debug/loader port
//
// Ports:
//   clk, resetN                      clock; asynchronous active-low reset
//   cpuReq/cpuWe/cpuAddr/cpuWdata    CPU access request (We=1 write)
//   cpuRdata/cpuDone/cpuStall        CPU registered read data, completion pulse, stall
//   dbgReq/dbgWe/dbgAddr/dbgWdata    debug/loader access request
//   dbgRdata/dbgDone                 debug registered read data, completion pulse
//   memEn/memWe/memAddr/memWdata     shared memory command
//   memRdata/memReady                shared memory response
//   errTimeout                       sticky access-timeout flag
//
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort accesses that see
// no memReady for 15 access cycles. Without it, accesses wait indefinitely.

module mem_arbiter (
    input  logic        clk,
    input  logic        resetN,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWdata,
    output logic [31:0] cpuRdata,
    output logic        cpuDone,
    output logic        cpuStall,
    input  logic        dbgReq,
    input  logic        dbgWe,
    input  logic [31:0] dbgAddr,
    input  logic [31:0] dbgWdata,
    output logic [31:0] dbgRdata,
    output logic        dbgDone,
    output logic        memEn,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memReady,
    output logic        errTimeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_ACC = 2'd1;
    localparam logic [1:0] DBG_ACC = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // owner / last_grant encoding: 0 = CPU, 1 = DBG
    logic [1:0]  state;
    logic        owner;
    logic        last_grant;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [3:0]  tmo_cnt;
    logic        err_timeout_q;
`endif

    logic in_access;
    assign in_access = (state == CPU_ACC) || (state == DBG_ACC);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            cpuRdata   <= 32'h0;
            dbgRdata   <= 32'h0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            tmo_cnt       <= 4'd0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // CPU wins a tie only when DBG was served last
                    if (cpuReq && (!dbgReq || last_grant)) begin
                        state     <= CPU_ACC;
                        owner     <= 1'b0;
                        lat_we    <= cpuWe;
                        lat_addr  <= cpuAddr;
                        lat_wdata <= cpuWdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        tmo_cnt   <= 4'd0;
`endif
                    end else if (dbgReq) begin
                        state     <= DBG_ACC;
                        owner     <= 1'b1;
                        lat_we    <= dbgWe;
                        lat_addr  <= dbgAddr;
                        lat_wdata <= dbgWdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        tmo_cnt   <= 4'd0;
`endif
                    end
                end
                CPU_ACC, DBG_ACC: begin
                    if (memReady) begin
                        if (!lat_we) begin
                            if (owner) dbgRdata <= memRdata;
                            else       cpuRdata <= memRdata;
                        end
                        state <= RELEASE;
`ifdef MEM_ARBITER_TIMEOUT_EN
                    end else if (tmo_cnt == 4'd14) begin
                        // this is the 15th cycle without memReady: count
                        // reaches 15 on this edge and the access is dropped
                        tmo_cnt       <= 4'd15;
                        err_timeout_q <= 1'b1;
                        if (!lat_we) begin
                            if (owner) dbgRdata <= 32'hDEADBEEF;
                            else       cpuRdata <= 32'hDEADBEEF;
                        end
                        state <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
`endif
                    end
                end
                RELEASE: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign memEn    = in_access;
    assign memWe    = in_access & lat_we;
    assign memAddr  = in_access ? lat_addr  : 32'h0;
    assign memWdata = in_access ? lat_wdata : 32'h0;

    assign cpuDone  = (state == RELEASE) && !owner;
    assign dbgDone  = (state == RELEASE) &&  owner;
    assign cpuStall = cpuReq & ~cpuDone;

`ifdef MEM_ARBITER_TIMEOUT_EN
    assign errTimeout = err_timeout_q;
`else
    assign errTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetN;
    logic        cpuReq, cpuWe, dbgReq, dbgWe;
    logic [31:0] cpuAddr, cpuWdata, dbgAddr, dbgWdata;
    logic [31:0] cpuRdata, dbgRdata;
    logic        cpuDone, cpuStall, dbgDone;
    logic        memEn, memWe, memReady, errTimeout;
    logic [31:0] memAddr, memWdata, memRdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .resetN(resetN),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
        .cpuRdata(cpuRdata), .cpuDone(cpuDone), .cpuStall(cpuStall),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
        .dbgRdata(dbgRdata), .dbgDone(dbgDone),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady), .errTimeout(errTimeout)
    );

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          ready_delay = 0;
    int          resp_cnt = 0;
    int          acc_cnt  = 0;
    bit          mon_off  = 1'b1;
    logic [31:0] cpu_rd = 32'h0;
    logic [31:0] dbg_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h40) ? 32'h12345678 : ~a;
    endfunction

    // memory responder: memReady after ready_delay idle access cycles
    initial begin
        memReady = 1'b0;
        memRdata = 32'h0;
        forever begin
            @(negedge clk);
            if (memEn) begin
                memReady = (resp_cnt == ready_delay);
                resp_cnt++;
            end else begin
                memReady = 1'b0;
                resp_cnt = 0;
            end
            memRdata = mem_model(memAddr);
        end
    end

    // monitor: compares the memory command and every Done against the scoreboard
    always @(negedge clk) begin
        if (mon_off) begin
            acc_cnt = 0;
        end else begin
            if (memEn) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_memEn", 32'd1, 32'd0);
                end else begin
                    chk("memAddr", memAddr, sbq[0].addr);
                    chk("memWe", {31'b0, memWe}, {31'b0, sbq[0].we});
                    chk("memWdata", memWdata, sbq[0].wdata);
                end
                acc_cnt++;
            end
            if (cpuDone || dbgDone) begin
                chk("done_onehot", {31'b0, cpuDone & dbgDone}, 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_who", {31'b0, dbgDone}, {31'b0, e.who});
                    chk(e.who ? "dbgRdata" : "cpuRdata", e.who ? dbgRdata : cpuRdata, e.rdata);
                    chk("access_cycles", acc_cnt, e.cycles);
                end
                acc_cnt = 0;
            end
        end
    end

    function automatic exp_t mk(input bit who, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd, input int cyc);
        exp_t e;
        e.who = who; e.we = we; e.addr = addr; e.wdata = wdata; e.cycles = cyc;
        if (we) begin
            e.rdata = who ? dbg_rd : cpu_rd;
        end else begin
            e.rdata = rd;
            if (who) dbg_rd = rd; else cpu_rd = rd;
        end
        return e;
    endfunction

    task automatic do_access(input bit who, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int delay, input int exp_cyc,
                             input logic [31:0] rd, input bit mutate);
        int got = 0;
        sbq.push_back(mk(who, we, addr, wdata, rd, exp_cyc));
        ready_delay = delay;
        if (who) begin
            dbgWe = we; dbgAddr = addr; dbgWdata = wdata; dbgReq = 1'b1;
        end else begin
            cpuWe = we; cpuAddr = addr; cpuWdata = wdata; cpuReq = 1'b1;
        end
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (mutate && i == 2) begin
                dbgAddr = 32'hBAD0; dbgWdata = 32'h0; dbgWe = 1'b0;
                cpuAddr = 32'hBAD4; cpuWdata = 32'h0; cpuWe = 1'b0;
            end
            if (!who && i == 1) chk("cpuStall_busy", {31'b0, cpuStall}, 32'd1);
            if (who ? dbgDone : cpuDone) begin
                got = i;
                if (!who) chk("cpuStall_at_done", {31'b0, cpuStall}, 32'd0);
                break;
            end
        end
        cpuReq = 1'b0;
        dbgReq = 1'b0;
        chk("edges_to_done", got, exp_cyc + 1);
    endtask

    task automatic both_access(input int n, input logic [31:0] ca, input logic [31:0] da,
                               input logic [31:0] crd, input logic [31:0] drd);
        int done_n = 0;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) sbq.push_back(mk(1'b0, 1'b0, ca, 32'h0, crd, 1));
            else            sbq.push_back(mk(1'b1, 1'b0, da, 32'h0, drd, 1));
        end
        ready_delay = 0;
        cpuWe = 1'b0; cpuAddr = ca; cpuWdata = 32'h0;
        dbgWe = 1'b0; dbgAddr = da; dbgWdata = 32'h0;
        cpuReq = 1'b1; dbgReq = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (cpuDone || dbgDone) done_n++;
            if (done_n == n) break;
        end
        cpuReq = 1'b0; dbgReq = 1'b0;
        chk("both_done_count", done_n, n);
    endtask

    task automatic reset_abort();
        mon_off = 1'b1;
        resetN = 1'b0;
        #1;
        chk("rst_memEn", {31'b0, memEn}, 32'd0);
        chk("rst_cpuDone", {31'b0, cpuDone}, 32'd0);
        chk("rst_cpuRdata", cpuRdata, 32'h0);
        chk("rst_dbgRdata", dbgRdata, 32'h0);
        chk("rst_errTimeout", {31'b0, errTimeout}, 32'd0);
        cpuReq = 1'b0; dbgReq = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_done", {31'b0, cpuDone | dbgDone}, 32'd0);
        sbq.delete();
        cpu_rd = 32'h0; dbg_rd = 32'h0;
        resetN = 1'b1;
        @(negedge clk);
        mon_off = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 32'h0; cpuWdata = 32'h0;
        dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = 32'h0; dbgWdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_memEn", {31'b0, memEn}, 32'd0);
        chk("reset_memWe", {31'b0, memWe}, 32'd0);
        chk("reset_memAddr", memAddr, 32'h0);
        chk("reset_memWdata", memWdata, 32'h0);
        chk("reset_cpuRdata", cpuRdata, 32'h0);
        chk("reset_dbgRdata", dbgRdata, 32'h0);
        chk("reset_done", {30'b0, cpuDone, dbgDone}, 32'd0);
        chk("reset_cpuStall", {31'b0, cpuStall}, 32'd0);
        chk("reset_errTimeout", {31'b0, errTimeout}, 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        mon_off = 1'b0;
        @(posedge clk); #1;

        // simultaneous requests right after reset: CPU, DBG, CPU, DBG
        both_access(4, 32'h200, 32'h300, 32'hFFFFFDFF, 32'hFFFFFCFF);
        @(posedge clk); #1;

        // single CPU read, immediate ready
        do_access(1'b0, 1'b0, 32'h40, 32'h0, 0, 1, 32'h12345678, 1'b0);
        @(posedge clk); #1;

        // DBG write, ready delayed 4 cycles, inputs changed mid-access
        do_access(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 4, 5, 32'h0, 1'b1);
        @(posedge clk); #1;

        // CPU write leaves cpuRdata alone
        do_access(1'b0, 1'b1, 32'h44, 32'h55AA55AA, 2, 3, 32'h0, 1'b0);
        chk("cpuRdata_after_write", cpuRdata, 32'h12345678);
        @(posedge clk); #1;

        // reset in the middle of a CPU access
        sbq.push_back(mk(1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 0));
        ready_delay = 50;
        cpuWe = 1'b0; cpuAddr = 32'h60; cpuWdata = 32'h0; cpuReq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midacc_memEn", {31'b0, memEn}, 32'd1);
        reset_abort();

        // after reset CPU wins the first tie again, then normal service
        both_access(2, 32'h80, 32'h84, 32'hFFFFFF7F, 32'hFFFFFF7B);
        @(posedge clk); #1;

`ifdef MEM_ARBITER_TIMEOUT_EN
        do_access(1'b0, 1'b0, 32'h140, 32'h0, 1000, 15, 32'hDEADBEEF, 1'b0);
        chk("errTimeout_set", {31'b0, errTimeout}, 32'd1);
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h144, 32'h0, 0, 1, 32'hFFFFFEBB, 1'b0);
        chk("errTimeout_sticky", {31'b0, errTimeout}, 32'd1);
        @(posedge clk); #1;
        reset_abort();
`else
        begin
            int seen = 0;
            sbq.push_back(mk(1'b0, 1'b0, 32'h140, 32'h0, 32'h0, 0));
            ready_delay = 1000;
            cpuWe = 1'b0; cpuAddr = 32'h140; cpuWdata = 32'h0; cpuReq = 1'b1;
            repeat (30) begin
                @(posedge clk); #1;
                if (cpuDone || dbgDone) seen++;
            end
            chk("stuck_no_done", seen, 0);
            chk("stuck_memEn", {31'b0, memEn}, 32'd1);
            chk("stuck_memAddr", memAddr, 32'h140);
            chk("stuck_errTimeout", {31'b0, errTimeout}, 32'd0);
            reset_abort();
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
